chroni_text_gen: RTL and testbench

- Parametrised text-mode pixel generator for the chroni video path; successor to the fixed 8x8 mono text generator.
- Consumes display-enable and line/frame strobes from the timing generator, fetches char, attribute and font bytes over the shared video memory port, and emits RGB565 pixels.
- Adds configurable columns, font height and memory bases, per-cell attributes, a 16-entry palette, a border region and row/scan tracking.

---
 rtl/chroni_pkg.sv | 20 ++
 rtl/chroni_text_gen_if.sv | 24 ++
 rtl/chroni_palette.sv | 21 ++
 rtl/chroni_text_gen.sv | 143 ++++++++++++++
 tb/tb_chroni_text_gen.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/chroni_pkg.sv
// chroni_pkg: shared pixel type, fetch slot schedule and default memory map for the chroni video path.
package chroni_pkg;
   localparam int R_W = 5;
   localparam int G_W = 6;
   localparam int B_W = 5;
   typedef struct packed {
      logic [R_W-1:0] r;
      logic [G_W-1:0] g;
      logic [B_W-1:0] b;
   } rgb565_t;
   localparam logic [2:0] SLOT_TEXT  = 3'd0;
   localparam logic [2:0] SLOT_ATTR  = 3'd2;
   localparam logic [2:0] SLOT_FONT  = 3'd4;
   localparam logic [2:0] SLOT_LATCH = 3'd6;
   localparam logic [2:0] SLOT_LOAD  = 3'd7;
   localparam logic [15:0] DEF_TEXT_BASE = 16'h0400;
   localparam logic [15:0] DEF_ATTR_BASE = 16'h0C00;
   localparam logic [15:0] DEF_FONT_BASE = 16'h0000;
   typedef enum logic {FETCH_IDLE, FETCH_ACTIVE} fetch_t;
endpackage

// File: rtl/chroni_text_gen_if.sv
// chroni_text_gen_if: timing strobes, palette port, video memory port and RGB565 pixel out.
interface chroni_text_gen_if #(parameter int ADDR_W = 16);
   logic              frame_start;
   logic              line_start;
   logic              h_de;
   logic              v_de;
   logic [15:0]       border_color;
   logic              pal_we;
   logic [3:0]        pal_idx;
   logic [15:0]       pal_data;
   logic [ADDR_W-1:0] addr_out;
   logic [7:0]        data_in;
   logic [4:0]        vga_r;
   logic [5:0]        vga_g;
   logic [4:0]        vga_b;
   modport master (
      output frame_start, line_start, h_de, v_de, border_color, pal_we, pal_idx, pal_data, data_in,
      input  addr_out, vga_r, vga_g, vga_b
   );
   modport slave (
      input  frame_start, line_start, h_de, v_de, border_color, pal_we, pal_idx, pal_data, data_in,
      output addr_out, vga_r, vga_g, vga_b
   );
endinterface

// File: rtl/chroni_palette.sv
// chroni_palette: 16-entry RGB565 register file, one write port, combinational fg/bg read ports.
module chroni_palette
   import chroni_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    i_we,
   input  logic [3:0] i_idx,
   input  rgb565_t i_data,
   input  logic [3:0] i_fg_idx,
   input  logic [3:0] i_bg_idx,
   output rgb565_t o_fg,
   output rgb565_t o_bg
);
   rgb565_t [15:0] r_mem;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_mem <= '0;
      else if (i_we) r_mem[i_idx] <= i_data;
   assign o_fg = r_mem[i_fg_idx];
   assign o_bg = r_mem[i_bg_idx];
endmodule

// File: rtl/chroni_text_gen.sv
// chroni_text_gen: text-mode RGB565 pixel generator, one cell fetched per 8-cycle slot window.
// Define CHRONI_TEXT_ATTR_EN for per-cell attribute fetch; otherwise fg=palette[15], bg=palette[0].
module chroni_text_gen
   import chroni_pkg::*;
#(
   parameter int COLS = 80,
   parameter int FONT_H = 8,
   parameter int ADDR_W = 16,
   parameter logic [ADDR_W-1:0] TEXT_BASE = ADDR_W'(DEF_TEXT_BASE),
   parameter logic [ADDR_W-1:0] ATTR_BASE = ADDR_W'(DEF_ATTR_BASE),
   parameter logic [ADDR_W-1:0] FONT_BASE = ADDR_W'(DEF_FONT_BASE)
) (
   input logic vga_clk,
   input logic reset,
   chroni_text_gen_if.slave bus
);
   localparam int PX_END = COLS * 8;
   localparam int PX_W = $clog2(PX_END + 1);
   fetch_t            r_state, w_state_nxt;
   logic [2:0]        r_slot;
   logic [7:0]        r_col, r_font, r_shifter, w_src, w_attr, w_glyph;
   logic [3:0]        r_scan;
   logic [ADDR_W-1:0] r_row_base, r_addr, w_font_addr;
   logic [PX_W-1:0]   r_px;
   logic              r_hde_d, w_run, w_at_text, w_at_attr, w_at_font, w_load, w_h_fall;
   rgb565_t           r_pix, w_fg, w_bg, w_color;
`ifdef CHRONI_TEXT_ATTR_EN
   logic [7:0]        r_char, r_attr, r_cur_attr;
   logic              w_at_latch;
   assign w_glyph = r_char;
`else
   logic              w_unused_attr_base;
   assign w_unused_attr_base = ^ATTR_BASE;
   assign w_glyph = bus.data_in;
`endif
   assign w_font_addr = FONT_BASE + ADDR_W'(w_glyph) * ADDR_W'(FONT_H) + ADDR_W'(r_scan);
   assign w_h_fall = r_hde_d && !bus.h_de && bus.v_de;
   always_ff @(posedge vga_clk or posedge reset)
      if (reset) r_state <= FETCH_IDLE;
      else r_state <= w_state_nxt;
   always_comb
      w_state_nxt = bus.line_start ? FETCH_ACTIVE :
                    (w_load && r_col == 8'(COLS - 1)) ? FETCH_IDLE : r_state;
   // a line_start in the same cycle pre-empts any slot action so the restart is clean
   always_comb begin
      w_run = r_state == FETCH_ACTIVE && !bus.line_start;
      w_at_text = w_run && r_slot == SLOT_TEXT;
      w_at_attr = w_run && r_slot == SLOT_ATTR;
      w_at_font = w_run && r_slot == SLOT_FONT;
`ifdef CHRONI_TEXT_ATTR_EN
      w_at_latch = w_run && r_slot == SLOT_LATCH;
`endif
      w_load = w_run && r_slot == SLOT_LOAD;
   end
   always_ff @(posedge vga_clk or posedge reset)
      if (reset) begin
         r_slot <= '0;
         r_col <= '0;
         r_addr <= '0;
         r_font <= '0;
`ifdef CHRONI_TEXT_ATTR_EN
         r_char <= '0;
         r_attr <= '0;
`endif
      end else if (bus.line_start) begin
         r_slot <= '0;
         r_col <= '0;
      end else if (r_state == FETCH_ACTIVE) begin
         r_slot <= r_slot + 3'd1;
         if (w_at_text) r_addr <= r_row_base + ADDR_W'(r_col);
`ifdef CHRONI_TEXT_ATTR_EN
         if (w_at_attr) begin
            r_char <= bus.data_in;
            r_addr <= ATTR_BASE + r_row_base - TEXT_BASE + ADDR_W'(r_col);
         end
         if (w_at_font) begin
            r_attr <= bus.data_in;
            r_addr <= w_font_addr;
         end
         if (w_at_latch) r_font <= bus.data_in;
`else
         if (w_at_attr) r_addr <= w_font_addr;
         if (w_at_font) r_font <= bus.data_in;
`endif
         if (w_load) r_col <= r_col + 8'd1;
      end
   always_ff @(posedge vga_clk or posedge reset)
      if (reset) begin
         r_scan <= '0;
         r_row_base <= TEXT_BASE;
      end else if (bus.frame_start) begin
         r_scan <= '0;
         r_row_base <= TEXT_BASE;
      end else if (w_h_fall) begin
         r_scan <= r_scan == 4'(FONT_H - 1) ? 4'd0 : r_scan + 4'd1;
         r_row_base <= r_scan == 4'(FONT_H - 1) ? r_row_base + ADDR_W'(COLS) : r_row_base;
      end
   // the load cycle is also the cell's first pixel, so bit7 is taken straight from the font latch
   always_comb begin
      w_src = w_load ? r_font : r_shifter;
`ifdef CHRONI_TEXT_ATTR_EN
      w_attr = w_load ? r_attr : r_cur_attr;
`else
      w_attr = 8'h0F;
`endif
      w_color = !(bus.h_de && bus.v_de) ? rgb565_t'(16'h0000) :
                r_px == PX_W'(PX_END) ? rgb565_t'(bus.border_color) :
                w_src[7] ? w_fg : w_bg;
   end
   always_ff @(posedge vga_clk or posedge reset)
      if (reset) begin
         r_hde_d <= 1'b0;
         r_px <= '0;
         r_shifter <= '0;
         r_pix <= '0;
`ifdef CHRONI_TEXT_ATTR_EN
         r_cur_attr <= '0;
`endif
      end else begin
         r_hde_d <= bus.h_de;
         r_px <= bus.line_start ? '0 : (bus.h_de && r_px != PX_W'(PX_END)) ? r_px + PX_W'(1) : r_px;
         r_shifter <= bus.h_de ? {w_src[6:0], 1'b0} : w_src;
         r_pix <= w_color;
`ifdef CHRONI_TEXT_ATTR_EN
         r_cur_attr <= w_attr;
`endif
      end
   chroni_palette u_palette (
      .clk     (vga_clk),
      .rst     (reset),
      .i_we    (bus.pal_we),
      .i_idx   (bus.pal_idx),
      .i_data  (rgb565_t'(bus.pal_data)),
      .i_fg_idx(w_attr[3:0]),
      .i_bg_idx(w_attr[7:4]),
      .o_fg    (w_fg),
      .o_bg    (w_bg)
   );
   assign bus.addr_out = r_addr;
   assign bus.vga_r = r_pix.r;
   assign bus.vga_g = r_pix.g;
   assign bus.vga_b = r_pix.b;
endmodule

// File: tb/tb_chroni_text_gen.sv
// tb_chroni_text_gen: directed lines against a byte memory model and a per-cycle pixel scoreboard.
module tb_chroni_text_gen;
   localparam int COLS = 4;
   localparam int FONT_H = 10;
   localparam logic [15:0] TEXT_B = 16'h0400;
   localparam logic [15:0] ATTR_B = 16'h0C00;
   localparam logic [15:0] FONT_B = 16'h0000;
   localparam logic [15:0] BORDER = 16'hF800;
`ifdef CHRONI_TEXT_ATTR_EN
   localparam bit ATTR = 1'b1;
   localparam logic [3:0] PW = 4'd3;
   localparam logic [15:0] BG0 = 16'h001F;
`else
   localparam bit ATTR = 1'b0;
   localparam logic [3:0] PW = 4'd15;
   localparam logic [15:0] BG0 = 16'h1234;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] mem [65536];
   logic [15:0] pal_m [16];
   logic [15:0] sb [$];
   logic [15:0] seen [8];
   logic [15:0] m_row;
   int m_scan, px, tests, fails;
   always #5 clk = ~clk;
   chroni_text_gen_if #(.ADDR_W(16)) bus ();
   chroni_text_gen #(
      .COLS(COLS), .FONT_H(FONT_H), .ADDR_W(16),
      .TEXT_BASE(TEXT_B), .ATTR_BASE(ATTR_B), .FONT_BASE(FONT_B)
   ) dut (
      .vga_clk(clk),
      .reset  (rst),
      .bus    (bus.slave)
   );
   always @(posedge clk) bus.data_in <= mem[bus.addr_out];
   function automatic logic [15:0] exp_pix(int p);
      logic [7:0] ch, at, f;
      int c;
      if (p >= COLS * 8) return BORDER;
      c = p / 8;
      ch = mem[16'(m_row + c)];
      at = ATTR ? mem[16'(ATTR_B + m_row - TEXT_B + c)] : 8'h0F;
      f = mem[16'(FONT_B + ch * FONT_H + m_scan)];
      return f[7 - p % 8] ? pal_m[at[3:0]] : pal_m[at[7:4]];
   endfunction
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask
   task automatic tick();
      logic [15:0] o;
      int p;
      bit hd;
      hd = bus.h_de;
      p = px;
      sb.push_back((bus.h_de && bus.v_de) ? exp_pix(px) : 16'h0000);
      if (bus.pal_we) pal_m[bus.pal_idx] = bus.pal_data;
      if (bus.h_de) px++;
      @(posedge clk);
      #1;
      o = {bus.vga_r, bus.vga_g, bus.vga_b};
      chk("pixel", o, sb.pop_front());
      if (hd && p < 8) seen[p] = o;
`ifndef CHRONI_TEXT_ATTR_EN
      chk("no_attr_fetch", {15'd0, bus.addr_out[15:10] == 6'd3}, 16'd0);
`endif
   endtask
   task automatic pal_load();
      for (int i = 0; i < 16; i++) begin
         bus.pal_we = 1'b1;
         bus.pal_idx = 4'(i);
         bus.pal_data = i == 0 ? 16'h1234 : i == 1 ? 16'h001F : i == 15 ? 16'hFFFF : 16'($urandom);
         tick();
      end
      bus.pal_we = 1'b0;
   endtask
   task automatic line(input bit fs, input int w, input int pal_at, input int rst_at);
      logic [15:0] last_font;
      px = 0;
      if (fs) begin
         m_scan = 0;
         m_row = TEXT_B;
      end
      bus.frame_start = fs;
      bus.line_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      bus.line_start = 1'b0;
      for (int k = 1; k < 8; k++) begin
         tick();
         if (k == 1) chk("text_addr", bus.addr_out, m_row);
         if (k == (ATTR ? 5 : 3)) chk("font_addr", bus.addr_out, 16'(FONT_B + mem[m_row] * FONT_H + m_scan));
`ifdef CHRONI_TEXT_ATTR_EN
         if (k == 3) chk("attr_addr", bus.addr_out, 16'(ATTR_B + m_row - TEXT_B));
`endif
      end
      last_font = 16'(FONT_B + mem[16'(m_row + COLS - 1)] * FONT_H + m_scan);
      bus.h_de = 1'b1;
      for (int i = 0; i < w; i++) begin
         if (i == rst_at) begin
            #3 rst = 1'b1;
            #1;
            chk("rst_addr", bus.addr_out, 16'h0000);
            chk("rst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 16'h0000);
            bus.h_de = 1'b0;
            tick();
            tick();
            rst = 1'b0;
            for (int j = 0; j < 16; j++) pal_m[j] = 16'h0000;
            m_scan = 0;
            m_row = TEXT_B;
            return;
         end
         bus.pal_we = i == pal_at;
         bus.pal_idx = PW;
         bus.pal_data = 16'h07E0;
         tick();
         bus.pal_we = 1'b0;
         if (i == COLS * 8 || (i == w - 1 && w > COLS * 8)) chk("border_addr_hold", bus.addr_out, last_font);
      end
      bus.h_de = 1'b0;
      tick();
      if (m_scan == FONT_H - 1) begin
         m_scan = 0;
         m_row = m_row + 16'(COLS);
      end else m_scan++;
      tick();
      tick();
   endtask
   initial begin
      logic [7:0] pat;
      pat = 8'hA5;
      tests = 0;
      fails = 0;
      px = 0;
      m_scan = 0;
      m_row = TEXT_B;
      bus.frame_start = 1'b0;
      bus.line_start = 1'b0;
      bus.h_de = 1'b0;
      bus.v_de = 1'b0;
      bus.border_color = BORDER;
      bus.pal_we = 1'b0;
      bus.pal_idx = 4'd0;
      bus.pal_data = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 64; i++) mem[TEXT_B + i] = 8'($urandom_range(32, 95));
      mem[TEXT_B] = 8'h41;
      mem[ATTR_B] = 8'h1F;
      mem[ATTR_B + 1] = 8'h23;
      mem[16'h41 * FONT_H] = 8'hA5;
      for (int i = 0; i < 16; i++) pal_m[i] = 16'h0000;
      tick();
      tick();
      chk("reset_addr", bus.addr_out, 16'h0000);
      #2 rst = 1'b0;
      pal_load();
      bus.v_de = 1'b1;
      line(1'b1, 32, -1, -1);
      for (int i = 0; i < 8; i++) chk("first_cell", seen[i], pat[7 - i] ? 16'hFFFF : BG0);
      for (int l = 1; l < FONT_H; l++) line(1'b0, 32, l == 2 ? 5 : -1, -1);
      line(1'b0, 48, -1, -1);
      line(1'b0, 32, -1, -1);
      line(1'b1, 32, -1, 12);
      pal_load();
      line(1'b1, 32, -1, -1);
      line(1'b0, 32, 9, -1);
      bus.v_de = 1'b0;
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
